mcycle_ctrl: RTL

Sequencer for the shared multi-cycle multiply/divide unit in the pipelined core. It accepts a MUL/DIV request from the Execute stage and latches the operands and destination register. It then issues a one-cycle start pulse to the unit, stalls the F/D/E stages while the unit is busy, and returns the result with a one-cycle valid pulse into the E→M result path. Two further features: a divide-by-zero fast path and a watchdog timeout.

---
 rtl/mcycle_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/mcycle_ctrl.sv
// Sequencer for the shared multi-cycle MUL/DIV unit: latches an E-stage request,
// pulses the unit, stalls F/D/E while it runs and returns a one-cycle result.
module mcycle_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_op,
    input  logic [3:0]       req_rd,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             m_start,
    output logic             m_op,
    output logic [WIDTH-1:0] m_opnd1,
    output logic [WIDTH-1:0] m_opnd2,
    input  logic             m_busy,
    input  logic [WIDTH-1:0] m_result,
    output logic             stall,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [3:0]       res_rd,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT);
    // Abort is decided one WAIT cycle early so DONE lands TIMEOUT+1 cycles after acceptance.
    localparam logic [CW-1:0] ABORT_CNT = CW'(TIMEOUT - 2);

    state_t        state, next_state;
    logic [CW-1:0] wait_cnt;
    logic          accept, div_zero, done_ok, abort;

    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        done_ok    = 1'b0;
        abort      = 1'b0;
        div_zero   = req_op && (op_b == '0);
        unique case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    accept     = 1'b1;
                    next_state = div_zero ? DONE : START;
                end
            end
            START: next_state = WAIT;
            WAIT: begin
                if (wait_cnt != '0 && !m_busy) begin
                    done_ok    = 1'b1;
                    next_state = DONE;
                end else if (wait_cnt == ABORT_CNT) begin
                    abort      = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase

        m_start   = (state == START);
        res_valid = (state == DONE);
        stall     = accept || (state == START) || (state == WAIT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            m_op     <= 1'b0;
            m_opnd1  <= '0;
            m_opnd2  <= '0;
            res_rd   <= '0;
            res_data <= '0;
            err      <= 1'b0;
        end else begin
            state <= next_state;

            if (state == START) begin
                wait_cnt <= '0;
            end else if (state == WAIT && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + CW'(1);
            end

            if (accept) begin
                m_op    <= req_op;
                m_opnd1 <= op_a;
                m_opnd2 <= op_b;
                res_rd  <= req_rd;
                err     <= 1'b0;
                if (div_zero) begin
                    res_data <= '1;
                end
            end

            if (done_ok) begin
                res_data <= m_result;
                err      <= 1'b0;
            end

            if (abort) begin
                res_data <= '0;
                err      <= 1'b1;
            end
        end
    end

endmodule
